fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Purpose : instruction fetch sequencer. It requests a word at PC, holds the
//           returned instruction until the datapath commits it, and then
//           computes the next PC from the held instruction.
// Latency : imem_ack in cycle N gives inst_valid in N+1. advance in cycle M
//           gives imem_req for the new PC in M+1.
// Backpressure: the held instruction stays put until advance. An ack timeout
//           or a misaligned target raises a sticky fault, and the unit halts
//           until rst.
// Ports   : clk/rst (sync, active-high); PCsrc/jr_addr/advance from the
//           controller; imem_req/imem_addr/imem_ack/imem_rdata to memory;
//           Inst/inst_valid/PC/PCplus4/fault/retired to the core.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  PCsrc,
    input  logic [31:0] jr_addr,
    input  logic        advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Inst,
    output logic        inst_valid,
    output logic [31:0] PC,
    output logic [31:0] PCplus4,
    output logic [1:0]  fault,
    output logic [31:0] retired
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] LAST_WAIT = WW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, HALT = 2'd2} state_t;

    state_t        state, state_nxt;
    logic [WW-1:0] wait_cnt;
    logic [31:0]   next_pc;
    logic [31:0]   branch_off;
    logic          misaligned;

    assign PCplus4    = PC + 32'd4;
    assign imem_addr  = PC;
    // Gated with rst so that no request leaks out while reset is held.
    assign imem_req   = (state == FETCH) && !rst;
    assign inst_valid = (state == HOLD);

    assign branch_off = {{14{Inst[15]}}, Inst[15:0], 2'b00};

    always_comb begin
        next_pc = PCplus4;
        case (PCsrc)
            2'd0:    next_pc = PCplus4 + branch_off;
            2'd1:    next_pc = PCplus4;
            2'd2:    next_pc = {PCplus4[31:28], Inst[25:0], 2'b00};
            default: next_pc = jr_addr;
        endcase
    end

    // Only the jr path can produce a misaligned target.
    assign misaligned = (next_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: begin
                // An ack in the last allowed cycle wins over the timeout.
                if (imem_ack)                   state_nxt = HOLD;
                else if (wait_cnt == LAST_WAIT) state_nxt = HALT;
            end
            HOLD: begin
                if (advance) state_nxt = misaligned ? HALT : FETCH;
            end
            default: state_nxt = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            PC       <= RESET_PC;
            Inst     <= 32'd0;
            fault    <= 2'd0;
            retired  <= 32'd0;
            wait_cnt <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack)                   Inst     <= imem_rdata;
                    else if (wait_cnt == LAST_WAIT) fault    <= 2'd1;
                    else                            wait_cnt <= wait_cnt + 1'b1;
                end
                HOLD: begin
                    if (advance) begin
                        PC       <= next_pc;
                        retired  <= retired + 32'd1;
                        wait_cnt <= '0;
                        if (misaligned) fault <= 2'd2;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
